tow_scorer: RTL and testbench
=============================

// Module: tow_scorer
// PURPOSE
//  Downstream of the round-decision path: consumes the one-cycle winrnd pulse plus right/tie
//  qualifiers and moves the tug-of-war light one step toward the round winner.
//  Owns the clr strobe that re-arms push-button latching after each round.
//  Detects match end (light reaches either end) and freezes the game until reset.
// PARAMETERS
//  HALF     4   steps from centre to either end; LED count = 2*HALF+1
//  CLR_CYC  4   cycles clr is held high after each accepted round (>=1)
//  FLASH_W  24  flash counter width; win LED toggles every 2^(FLASH_W-1) cycles
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  winrnd     in   1        one-cycle round-complete pulse (synchronous to clk)
//  right      in   1        round winner: 1=right player, 0=left (valid when winrnd=1)
//  tie        in   1        round was a tie (valid when winrnd=1; overrides right)
//  clr        out  1        clears upstream push latches
//  leds       out  2*HALF+1 one-hot light position; bit 0 = leftmost
//  left_win   out  1        left player has won the match (sticky)
//  right_win  out  1        right player has won the match (sticky)
// BEHAVIOUR
//  - Reset: pos=HALF (centre), state=PLAY, clr=0, left_win=right_win=0, leds=1<<HALF.
//  - pos width $clog2(2*HALF+1), unsigned; leds = one-hot decode of pos (registered).
//  - FSM states PLAY, CLEAR, WIN:
//    PLAY : winrnd=1 & tie=1 -> pos unchanged, -> CLEAR.
//           winrnd=1 & tie=0 & right=1 -> pos+1; right=0 -> pos-1.
//           new pos==2*HALF -> right_win=1, -> WIN; new pos==0 -> left_win=1, -> WIN;
//           else -> CLEAR. winrnd=0 -> stay.
//    CLEAR: clr=1 for exactly CLR_CYC cycles (down-counter loaded on entry), then -> PLAY.
//           winrnd during CLEAR ignored (no move, counter not reloaded).
//    WIN  : clr held 1 continuously; winrnd ignored; pos/leds frozen; exit only by rst.
//  - clr is registered: first high cycle is the cycle after winrnd is sampled.
//  - pos update latency: 1 cycle after winrnd sampled; leds reflect same edge.
//  - pos never wraps: end positions always enter WIN, so no step beyond 0 or 2*HALF.
//  - left_win and right_win mutually exclusive; never both 1.
//  - rst asserted in any state (incl. mid-CLEAR) returns all regs to reset values immediately.
// CONFIGURATION
//  - TOW_FLASH_EN defined: in WIN, the lit leds bit toggles at 2^(FLASH_W-1)-cycle rate
//    via a free-running FLASH_W-bit counter cleared on WIN entry (first half-period lit).
//  - Not defined: WIN leds steady on; no flash counter synthesised.
//  - All other behaviour identical in both builds.
// STRUCTURE
//  - Package tow_pkg: state enum {PLAY, CLEAR, WIN}; function led_n(HALF)=2*HALF+1.
//  - One sub-module: tow_flasher (counter + toggle, instantiated only under TOW_FLASH_EN).
//  - Top body: FSM, position register, clr down-counter, one-hot decoder.
// TESTING (HALF=4, CLR_CYC=4, TOW_FLASH_EN undefined unless noted)
//  1. rst pulse -> leds=9'b000010000, clr=0, left_win=right_win=0.
//  2. winrnd,right=1 -> next cycle leds=9'b000100000; clr=1 for exactly 4 cycles then 0.
//  3. winrnd,tie=1,right=1 -> leds unchanged; clr still pulses 4 cycles.
//  4. winrnd pulse 2 cycles into CLEAR -> ignored; leds unchanged, clr ends on schedule.
//  5. 4 right rounds -> leds=9'b100000000, right_win=1, clr stays 1; further winrnd no effect;
//     with TOW_FLASH_EN (FLASH_W=4) bit 8 toggles every 8 cycles.
//  6. rst asserted mid-CLEAR after 2 left rounds -> same cycle asynchronously: leds=centre, clr=0.

Source files
------------

// File: rtl/tow_pkg.sv
// tow_pkg: shared state encoding and LED-count helper for the tug-of-war scorer
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CLEAR = 2'd1,
        WIN   = 2'd2
    } tow_state_t;

    function automatic int led_n(input int half);
        return 2 * half + 1;
    endfunction

endpackage

// File: rtl/tow_flasher.sv
// tow_flasher: blink enable for the winning LED; counter held at zero until run rises
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset
//   run  in   high while the match is won; low holds the counter cleared
//   lit  out  high during the first half of each 2^W-cycle period
module tow_flasher #(
    parameter int W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic lit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= run ? cnt + W'(1) : '0;
    end

    assign lit = ~cnt[W-1];

endmodule

// File: rtl/tow_scorer.sv
// tow_scorer: moves the tug-of-war light one step per round, strobes clr, latches the match winner
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   winrnd     in   one-cycle round-complete pulse
//   right      in   round winner, 1=right 0=left (valid with winrnd)
//   tie        in   round tied, overrides right (valid with winrnd)
//   clr        out  clears upstream push latches after each round, held high once won
//   leds       out  one-hot light position, bit 0 leftmost
//   left_win   out  sticky left-player match win
//   right_win  out  sticky right-player match win
//   Build macro TOW_FLASH_EN: blink the winning LED via tow_flasher; undefined keeps it steady.
module tow_scorer
    import tow_pkg::*;
#(
    parameter int HALF    = 4,
    parameter int CLR_CYC = 4,
    parameter int FLASH_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    winrnd,
    input  logic                    right,
    input  logic                    tie,
    output logic                    clr,
    output logic [led_n(HALF)-1:0] leds,
    output logic                    left_win,
    output logic                    right_win
);

    localparam int N  = led_n(HALF);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(CLR_CYC + 1);
    localparam logic [PW-1:0] PMAX = PW'(2 * HALF);
    localparam logic [PW-1:0] PMID = PW'(HALF);

    if (HALF < 1 || CLR_CYC < 1 || FLASH_W < 2) begin : g_bad_param
        $error("tow_scorer: HALF>=1, CLR_CYC>=1 and FLASH_W>=2 required");
    end

    tow_state_t    state;
    logic [PW-1:0] pos;
    logic [PW-1:0] np;
    logic [CW-1:0] cnt;
    logic [N-1:0]  leds_q;
    logic          accept;
    logic          mv;

    always_comb begin
        accept = state == PLAY && winrnd;
        mv     = accept && !tie;
        np     = !mv ? pos : right ? pos + PW'(1) : pos - PW'(1);
    end

    // PLAY is never entered at an end position, so a tie can't land on 0 or PMAX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PLAY;
            pos       <= PMID;
            cnt       <= '0;
            clr       <= 1'b0;
            left_win  <= 1'b0;
            right_win <= 1'b0;
            leds_q    <= N'(1) << HALF;
        end else if (accept) begin
            pos       <= np;
            leds_q    <= N'(1) << np;
            clr       <= 1'b1;
            cnt       <= CW'(CLR_CYC - 1);
            state     <= (np == PMAX || np == '0) ? WIN : CLEAR;
            right_win <= np == PMAX;
            left_win  <= np == '0;
        end else if (state == CLEAR) begin
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                state <= PLAY;
                clr   <= 1'b0;
            end
        end
    end

`ifdef TOW_FLASH_EN
    logic lit;

    tow_flasher #(.W(FLASH_W)) u_flasher (
        .clk (clk),
        .rst (rst),
        .run (state == WIN),
        .lit (lit)
    );

    assign leds = (state == WIN && !lit) ? '0 : leds_q;
`else
    assign leds = leds_q;
`endif

endmodule

// File: tb/tb_tow_scorer.sv
// tb_tow_scorer: randomized self-checking bench for tow_scorer against a round-level model
module tb_tow_scorer;

    localparam int HALF    = 4;
    localparam int CLR_CYC = 4;
    localparam int N       = 2 * HALF + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         winrnd = 1'b0;
    logic         right = 1'b0;
    logic         tie = 1'b0;
    logic         clr;
    logic [N-1:0] leds;
    logic         left_win;
    logic         right_win;

    int n_chk = 0;
    int n_fail = 0;

    int mpos = HALF;
    int mwin = 0;

    tow_scorer #(.HALF(HALF), .CLR_CYC(CLR_CYC), .FLASH_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .winrnd    (winrnd),
        .right     (right),
        .tie       (tie),
        .clr       (clr),
        .leds      (leds),
        .left_win  (left_win),
        .right_win (right_win)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_leds();
        logic [N-1:0] v;
        v = '0;
        v[mpos] = 1'b1;
        return v;
    endfunction

    task automatic check_status(input string name);
        n_chk++;
        if (leds !== exp_leds() || left_win !== (mwin == 1) || right_win !== (mwin == 2)) begin
            n_fail++;
            $display("FAIL %s: leds=%b lw=%b rw=%b, expected leds=%b lw=%b rw=%b",
                     name, leds, left_win, right_win, exp_leds(), mwin == 1, mwin == 2);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        winrnd = 1'b0;
        mpos = HALF;
        mwin = 0;
        @(negedge clk);
        n_chk++;
        if (clr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clr: clr=%b expected 0", clr);
        end
        check_status("reset_state");
        rst = 1'b0;
    endtask

    // Called at a negedge with the DUT in PLAY or WIN; ends at a negedge.
    // inj in 1..CLR_CYC-1 fires an extra winrnd that far into CLEAR, which must be ignored.
    task automatic do_round(input bit r, input bit t, input int inj, input string name);
        winrnd = 1'b1;
        right = r;
        tie = t;
        @(negedge clk);
        winrnd = 1'b0;
        right = 1'($urandom);
        tie = 1'($urandom);
        if (mwin == 0) begin
            if (!t) mpos += r ? 1 : -1;
            if (mpos == 2 * HALF) mwin = 2;
            if (mpos == 0) mwin = 1;
        end
        check_status(name);
        for (int i = 0; i <= CLR_CYC; i++) begin
            n_chk++;
            if (clr !== (mwin != 0 || i < CLR_CYC)) begin
                n_fail++;
                $display("FAIL %s_clr[%0d]: clr=%b expected %b", name, i, clr, mwin != 0 || i < CLR_CYC);
            end
            if (i < CLR_CYC) begin
                winrnd = (i == inj);
                @(negedge clk);
                winrnd = 1'b0;
                check_status(name);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_step();
        apply_reset();
        do_round(1'b1, 1'b0, -1, "step_right");
        do_round(1'b0, 1'b0, -1, "step_left");
    endtask

    task automatic test_tie();
        apply_reset();
        do_round(1'b1, 1'b1, -1, "tie_right");
        do_round(1'b0, 1'b1, -1, "tie_left");
    endtask

    task automatic test_ignore_in_clear();
        apply_reset();
        do_round(1'b1, 1'b0, 2, "ignore_clear_a");
        do_round(1'b0, 1'b0, 1, "ignore_clear_b");
        do_round(1'($urandom), 1'b0, CLR_CYC - 1, "ignore_clear_c");
    endtask

    task automatic test_right_win();
        apply_reset();
        for (int k = 0; k < HALF; k++) do_round(1'b1, 1'b0, -1, "right_walk");
        for (int k = 0; k < 3; k++) do_round(1'($urandom), 1'($urandom), -1, "right_frozen");
    endtask

    task automatic test_left_win();
        apply_reset();
        for (int k = 0; k < HALF; k++) do_round(1'b0, 1'b0, -1, "left_walk");
        for (int k = 0; k < 3; k++) do_round(1'($urandom), 1'($urandom), -1, "left_frozen");
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_round(1'b0, 1'b0, -1, "async_pre");
        winrnd = 1'b1;
        right = 1'b0;
        tie = 1'b0;
        @(negedge clk);
        winrnd = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        mpos = HALF;
        mwin = 0;
        #1;
        n_chk++;
        if (clr !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_clr: clr=%b expected 0", clr);
        end
        check_status("async_reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random_matches();
        for (int m = 0; m < 6; m++) begin
            apply_reset();
            for (int k = 0; k < 200 && mwin == 0; k++)
                do_round(1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, CLR_CYC), "random");
            n_chk++;
            if (mwin == 0) begin
                n_fail++;
                $display("FAIL random_match_end: no winner after 200 rounds, expected a winner");
            end
            do_round(1'($urandom), 1'($urandom), -1, "random_post_win");
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_tie();
        test_ignore_in_clear();
        test_right_win();
        test_left_win();
        test_async_reset();
        test_random_matches();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
